// File: rtl/req_err_sequencer.sv
// Capture controller for the request-error expected/seen mux: latches checker error pulses,
// serves them in fixed priority through err_en and hands each captured pair out on a valid/ready port.
module req_err_sequencer #(
  parameter int unsigned NSRC   = 5,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   err_pulse,
  input  logic              clear_all,
  output logic [2:0]        err_en,
  input  logic [63:0]       expc_err,
  input  logic [63:0]       seen_err,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [2:0]        rpt_src,
  output logic [63:0]       rpt_expc,
  output logic [63:0]       rpt_seen,
  output logic [NSRC-1:0]   pending,
  output logic [CNT_W-1:0]  err_total,
  output logic [CNT_W-1:0]  err_drop,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SELECT, REPORT} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [2:0]      sel;
  logic            found;
  logic            capture;
  logic [NSRC-1:0] clr_mask;
  logic [NSRC-1:0] drop_mask;
  logic [2:0]      pulse_cnt;
  logic [2:0]      drop_cnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (pending[i] && !found) begin
        sel   = 3'(i);
        found = 1'b1;
      end
    end
  end

  assign capture = (state == SELECT) && (wait_cnt == 4'd1);

  // A pulse landing on the capture edge of its own source re-arms pending and is not a drop.
  always_comb begin
    clr_mask = '0;
    if (capture) clr_mask[err_en - 3'd1] = 1'b1;
    drop_mask = err_pulse & pending & ~clr_mask;
    pulse_cnt = '0;
    drop_cnt  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      pulse_cnt = pulse_cnt + 3'(err_pulse[i]);
      drop_cnt  = drop_cnt + 3'(drop_mask[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      err_en    <= '0;
      rpt_valid <= 1'b0;
      rpt_src   <= '0;
      rpt_expc  <= '0;
      rpt_seen  <= '0;
      pending   <= '0;
      err_total <= '0;
      err_drop  <= '0;
      busy      <= 1'b0;
    end else begin
      pending   <= (pending & ~clr_mask) | err_pulse;
      err_total <= sat_add(err_total, pulse_cnt);
      err_drop  <= sat_add(err_drop, drop_cnt);
      case (state)
        IDLE: begin
          if (|pending) begin
            state    <= SELECT;
            busy     <= 1'b1;
            err_en   <= sel + 3'd1;
            wait_cnt <= 4'(SETTLE);
          end
        end
        SELECT: begin
          if (capture) begin
            rpt_expc  <= expc_err;
            rpt_seen  <= seen_err;
            rpt_src   <= err_en;
            rpt_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        REPORT: begin
          if (rpt_valid && rpt_ready) begin
            rpt_valid <= 1'b0;
            if (|pending) begin
              state    <= SELECT;
              err_en   <= sel + 3'd1;
              wait_cnt <= 4'(SETTLE);
            end else begin
              state  <= IDLE;
              busy   <= 1'b0;
              err_en <= '0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          err_en <= '0;
        end
      endcase
    end
  end

endmodule
